vadd_arb: RTL and testbench

Two-port arbiter and sequencer for the shared 16-lane × 16-bit vector adder. It accepts vector-add requests from two requesters over valid/ready handshakes and grants one at a time, round-robin. It captures the granted operands, runs them through the lane adders, and holds a registered result with requester ID until the consumer accepts it. It sits between the vector issue ports and the vector adder datapath, so the adder is instantiated once per vector unit.

---
 rtl/vadd_pkg.sv | 10 +
 rtl/vadd_arb_if.sv | 29 ++
 rtl/vadd_lane_add.sv | 13 +
 rtl/vadd_arb.sv | 98 +++++++++
 tb/tb_vadd_arb.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vadd_pkg.sv
// Shared constants and types for the two-port vector-add arbiter.
package vadd_pkg;
  localparam int LANES  = 16;
  localparam int LANE_W = 16;
  localparam int VEC_W  = LANES * LANE_W;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef logic port_id_t;
endpackage

// File: rtl/vadd_arb_if.sv
// Request/response bundle between the two vector issue ports, the arbiter and the result consumer.
interface vadd_arb_if;
  import vadd_pkg::*;

  logic               req0_valid;
  logic               req0_ready;
  logic [VEC_W-1:0]   req0_a;
  logic [VEC_W-1:0]   req0_b;
  logic               req1_valid;
  logic               req1_ready;
  logic [VEC_W-1:0]   req1_a;
  logic [VEC_W-1:0]   req1_b;
  logic               rsp_valid;
  logic               rsp_ready;
  port_id_t           rsp_id;
  logic [VEC_W-1:0]   rsp_sum;
  logic [LANES-1:0]   rsp_lane_ovf;
  logic               rsp_ovf;

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_sum, rsp_lane_ovf, rsp_ovf
  );

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_sum, rsp_lane_ovf, rsp_ovf
  );
endinterface

// File: rtl/vadd_lane_add.sv
// One lane of the vector adder: wrapping two's-complement add plus signed overflow flag.
// Purely combinational, zero latency, no flow control.
module vadd_lane_add
  import vadd_pkg::*;
(
  input  logic [LANE_W-1:0] a_i,
  input  logic [LANE_W-1:0] b_i,
  output logic [LANE_W-1:0] sum_o,
  output logic              ovf_o
);
  assign sum_o = a_i + b_i;
  assign ovf_o = (a_i[LANE_W-1] == b_i[LANE_W-1]) && (sum_o[LANE_W-1] != a_i[LANE_W-1]);
endmodule

// File: rtl/vadd_arb.sv
// Round-robin arbiter and sequencer for the shared 16-lane vector adder (VADD_ARB_PRIO_EN: fixed port-0 priority).
// Latency: 2 cycles from accept to rsp_valid; one request per 3 cycles at best.
// Backpressure: result held in RESP until rsp_ready; no request accepted outside IDLE, nothing buffered.
module vadd_arb
  import vadd_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  vadd_arb_if.slave   bus,
  output logic        busy
);
  state_t           state_q;
  port_id_t         id_q;
  logic [VEC_W-1:0] a_q, b_q, sum_q;
  logic [LANES-1:0] ovf_q;
  logic             rsp_vld_q;
  logic             busy_q;
  logic [VEC_W-1:0] lane_sum;
  logic [LANES-1:0] lane_ovf;
  logic             gnt1;
  logic             idle;
  logic             accept;

`ifdef VADD_ARB_PRIO_EN
  assign gnt1 = bus.req1_valid && !bus.req0_valid;
`else
  port_id_t last_grant_q;
  // On a tie the port that was not granted last time wins.
  assign gnt1 = bus.req1_valid && (!bus.req0_valid || (last_grant_q == 1'b0));
`endif

  // Gated with rst_n so the ready outputs drop the instant reset asserts.
  assign idle           = rst_n && (state_q == IDLE);
  assign bus.req0_ready = idle && bus.req0_valid && !gnt1;
  assign bus.req1_ready = idle && gnt1;
  assign accept         = idle && (bus.req0_valid || bus.req1_valid);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    vadd_lane_add u_lane (
      .a_i   (a_q[i*LANE_W +: LANE_W]),
      .b_i   (b_q[i*LANE_W +: LANE_W]),
      .sum_o (lane_sum[i*LANE_W +: LANE_W]),
      .ovf_o (lane_ovf[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      id_q         <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      sum_q        <= '0;
      ovf_q        <= '0;
      rsp_vld_q    <= 1'b0;
      busy_q       <= 1'b0;
`ifndef VADD_ARB_PRIO_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q     <= gnt1 ? bus.req1_a : bus.req0_a;
            b_q     <= gnt1 ? bus.req1_b : bus.req0_b;
            id_q    <= gnt1;
            busy_q  <= 1'b1;
            state_q <= EXEC;
`ifndef VADD_ARB_PRIO_EN
            last_grant_q <= gnt1;
`endif
          end
        end
        EXEC: begin
          sum_q     <= lane_sum;
          ovf_q     <= lane_ovf;
          rsp_vld_q <= 1'b1;
          state_q   <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_vld_q <= 1'b0;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rsp_valid    = rsp_vld_q;
  assign bus.rsp_id       = id_q;
  assign bus.rsp_sum      = sum_q;
  assign bus.rsp_lane_ovf = ovf_q;
  assign bus.rsp_ovf      = |ovf_q;
  assign busy             = busy_q;
endmodule

// File: tb/tb_vadd_arb.sv
// Scoreboard bench for vadd_arb: grant model and expected results captured at accept, compared at response.
module tb_vadd_arb;
  import vadd_pkg::*;

  typedef logic [VEC_W-1:0] vec_t;
  typedef struct packed {
    logic             id;
    logic [VEC_W-1:0] sum;
    logic [LANES-1:0] lovf;
    logic             ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  vadd_arb_if bus();

  vadd_arb dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input vec_t got, input vec_t exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic id, input vec_t a, input vec_t b);
    exp_t e;
    logic [15:0] x, y, s;
    e.id = id;
    for (int i = 0; i < LANES; i++) begin
      x = a[i*16 +: 16];
      y = b[i*16 +: 16];
      s = x + y;
      e.sum[i*16 +: 16] = s;
      e.lovf[i] = (x[15] == y[15]) && (s[15] != x[15]);
    end
    e.ovf = |e.lovf;
    return e;
  endfunction

  function automatic vec_t splat(input logic [15:0] v);
    vec_t r;
    for (int i = 0; i < LANES; i++) r[i*16 +: 16] = v;
    return r;
  endfunction

  function automatic vec_t rnd_vec();
    vec_t r;
    for (int i = 0; i < VEC_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Monitor state, shared with the stimulus process.
  exp_t sb[$];
  logic gnt_log[$];
  int   acc_cyc = 0;
  int   hs_cyc = 0;
  int   tput_n = 0;
  logic m_last = 1'b1;
  logic prev_vld = 1'b0;
  logic both_seen = 1'b0;
  logic rdy_busy_seen = 1'b0;
  logic tput_mode = 1'b0;
  logic gap_mode = 1'b0;

  always @(negedge clk) begin : mon
    logic p, e;
    exp_t x;
    if (rst_n) begin
      if (bus.req0_ready && bus.req1_ready) both_seen = 1'b1;
      if ((bus.req0_ready || bus.req1_ready) && busy) rdy_busy_seen = 1'b1;
      if ((bus.req0_ready && bus.req0_valid) || (bus.req1_ready && bus.req1_valid)) begin
        p = bus.req1_ready;
`ifdef VADD_ARB_PRIO_EN
        e = !bus.req0_valid;
`else
        e = (bus.req0_valid && bus.req1_valid) ? !m_last : bus.req1_valid;
`endif
        check_val("grant", vec_t'(p), vec_t'(e));
        m_last = p;
        gnt_log.push_back(p);
        if (tput_mode) begin
          if (tput_n > 0) check_val("accept_interval", vec_t'(cyc - acc_cyc), vec_t'(3));
          tput_n++;
        end
        if (gap_mode) begin
          check_val("hs_to_accept", vec_t'(cyc - hs_cyc), vec_t'(1));
          gap_mode = 1'b0;
        end
        acc_cyc = cyc;
        sb.push_back(model(p, p ? bus.req1_a : bus.req0_a, p ? bus.req1_b : bus.req0_b));
      end
      if (bus.rsp_valid && !prev_vld) check_val("latency", vec_t'(cyc - acc_cyc), vec_t'(2));
      prev_vld = bus.rsp_valid;
      if (bus.rsp_valid && bus.rsp_ready) begin
        hs_cyc = cyc;
        if (sb.size() == 0) begin
          check_val("unexpected_rsp", vec_t'(sb.size()), vec_t'(1));
        end else begin
          x = sb.pop_front();
          check_val("sb_id", vec_t'(bus.rsp_id), vec_t'(x.id));
          check_val("sb_sum", bus.rsp_sum, x.sum);
          check_val("sb_lane_ovf", vec_t'(bus.rsp_lane_ovf), vec_t'(x.lovf));
          check_val("sb_ovf", vec_t'(bus.rsp_ovf), vec_t'(x.ovf));
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_vld(input string tag);
    for (int i = 0; i < 20 && !bus.rsp_valid; i++) tick();
    check_val({tag, "_rsp_vld"}, vec_t'(bus.rsp_valid), vec_t'(1'b1));
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_rdy0"}, vec_t'(bus.req0_ready), '0);
    check_val({tag, "_rdy1"}, vec_t'(bus.req1_ready), '0);
    check_val({tag, "_rsp_vld"}, vec_t'(bus.rsp_valid), '0);
    check_val({tag, "_rsp_id"}, vec_t'(bus.rsp_id), '0);
    check_val({tag, "_rsp_sum"}, bus.rsp_sum, '0);
    check_val({tag, "_lane_ovf"}, vec_t'(bus.rsp_lane_ovf), '0);
    check_val({tag, "_ovf"}, vec_t'(bus.rsp_ovf), '0);
    check_val({tag, "_busy"}, vec_t'(busy), '0);
  endtask

  vec_t a, b, s_sum;
  logic s_id;
  logic [LANES-1:0] s_lovf;

  initial begin
    bus.req0_a = '0; bus.req0_b = '0; bus.req1_a = '0; bus.req1_b = '0;
    bus.rsp_ready = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #12;
    check_zero("reset");
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // 1: simple add on port 0
    bus.rsp_ready = 1'b1;
    bus.req0_a = splat(16'h0001);
    bus.req0_b = splat(16'h0002);
    bus.req0_valid = 1'b1;
    tick();
    bus.req0_valid = 1'b0;
    wait_vld("t1");
    check_val("t1_sum", bus.rsp_sum, splat(16'h0003));
    check_val("t1_id", vec_t'(bus.rsp_id), vec_t'(1'b0));
    check_val("t1_ovf", vec_t'(bus.rsp_ovf), vec_t'(1'b0));
    tick();
    check_val("t1_busy_after_hs", vec_t'(busy), vec_t'(1'b0));

    // 2: wrap and overflow on port 1
    a = '0; b = '0;
    a[5*16 +: 16] = 16'h7FFF; b[5*16 +: 16] = 16'h0001;
    a[15:0] = 16'hFFFF;       b[15:0] = 16'h0001;
    bus.req1_a = a; bus.req1_b = b;
    bus.req1_valid = 1'b1;
    tick();
    bus.req1_valid = 1'b0;
    wait_vld("t2");
    s_sum = bus.rsp_sum;
    check_val("t2_lane5", vec_t'(s_sum[5*16 +: 16]), vec_t'(16'h8000));
    check_val("t2_lane0", vec_t'(s_sum[15:0]), vec_t'(16'h0000));
    check_val("t2_lane_ovf", vec_t'(bus.rsp_lane_ovf), vec_t'(16'h0020));
    check_val("t2_ovf", vec_t'(bus.rsp_ovf), vec_t'(1'b1));
    check_val("t2_id", vec_t'(bus.rsp_id), vec_t'(1'b1));
    tick(2);

    // 3: both ports streaming, random operands
    gnt_log.delete();
    tput_n = 0;
    tput_mode = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    for (int i = 0; i < 60 && gnt_log.size() < 8; i++) begin
      bus.req0_a = rnd_vec(); bus.req0_b = rnd_vec();
      bus.req1_a = rnd_vec(); bus.req1_b = rnd_vec();
      tick();
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    tput_mode = 1'b0;
    tick(6);
    check_val("t3_accepts", vec_t'(gnt_log.size() >= 8), vec_t'(1'b1));
    for (int k = 0; k < 4; k++) begin
`ifdef VADD_ARB_PRIO_EN
      check_val("t3_grant_seq", vec_t'(gnt_log[k]), vec_t'(1'b0));
`else
      check_val("t3_grant_seq", vec_t'(gnt_log[k]), vec_t'(k % 2));
`endif
    end

    // 4: consumer stalls for 5 cycles
    bus.rsp_ready = 1'b0;
    bus.req0_a = rnd_vec(); bus.req0_b = rnd_vec();
    bus.req1_a = rnd_vec(); bus.req1_b = rnd_vec();
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    wait_vld("t4");
    s_sum = bus.rsp_sum;
    s_id = bus.rsp_id;
    s_lovf = bus.rsp_lane_ovf;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("t4_hold_vld", vec_t'(bus.rsp_valid), vec_t'(1'b1));
      check_val("t4_hold_sum", bus.rsp_sum, s_sum);
      check_val("t4_hold_id", vec_t'(bus.rsp_id), vec_t'(s_id));
      check_val("t4_hold_lovf", vec_t'(bus.rsp_lane_ovf), vec_t'(s_lovf));
      check_val("t4_no_ready", vec_t'({bus.req0_ready, bus.req1_ready}), '0);
    end
    gap_mode = 1'b1;
    bus.rsp_ready = 1'b1;
    tick(3);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    check_val("t4_accept_after_hs", vec_t'(gap_mode), vec_t'(1'b0));
    tick(6);

    // 5: reset pulsed while in EXEC
    bus.req0_a = rnd_vec(); bus.req0_b = rnd_vec();
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    tick();
    check_val("t5_in_exec", vec_t'({busy, bus.rsp_valid}), vec_t'(2'b10));
    #2;
    rst_n = 1'b0;
    sb.delete();
    m_last = 1'b1;
    prev_vld = 1'b0;
    gap_mode = 1'b0;
    #1;
    check_zero("t5_mid_rst");
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(4);
    check_val("t5_no_rsp", vec_t'(bus.rsp_valid), vec_t'(1'b0));
    check_val("t5_idle", vec_t'(busy), vec_t'(1'b0));
    bus.req0_a = rnd_vec(); bus.req0_b = rnd_vec();
    bus.req1_a = rnd_vec(); bus.req1_b = rnd_vec();
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    wait_vld("t5");
    check_val("t5_first_tie", vec_t'(bus.rsp_id), vec_t'(1'b0));
    tick(4);

    check_val("never_both_ready", vec_t'(both_seen), '0);
    check_val("ready_only_idle", vec_t'(rdy_busy_seen), '0);
    check_val("sb_drained", vec_t'(sb.size()), '0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
